// File: rtl/cnn_window_feeder_if.sv
// Bus bundle between the pixel source / CNN and cnn_window_feeder.
// The master side streams pixels and reports CNN results. The slave side
// (the feeder) returns ready, window and result information.
interface cnn_window_feeder_if;
    logic         PIX_VALID;
    logic [7:0]   PIX_IN;
    logic         PIX_READY;
    logic         START;
    logic [4:0]   X;
    logic [4:0]   Y;
    logic [199:0] IMGIN;
    logic         WIN_VALID;
    logic         CNN_DONE;
    logic [3:0]   CNN_OUT;
    logic [3:0]   RESULT;
    logic         RESULT_VALID;
    logic         BUSY;

    modport master (
        output PIX_VALID, PIX_IN, CNN_DONE, CNN_OUT,
        input  PIX_READY, START, X, Y, IMGIN, WIN_VALID, RESULT, RESULT_VALID, BUSY
    );

    modport slave (
        input  PIX_VALID, PIX_IN, CNN_DONE, CNN_OUT,
        output PIX_READY, START, X, Y, IMGIN, WIN_VALID, RESULT, RESULT_VALID, BUSY
    );
endinterface

// File: rtl/cnn_window_feeder.sv
// cnn_window_feeder: buffers an IMG_DIM x IMG_DIM 8-bit image that arrives
// in raster order. It then streams every 5x5 window to a CNN at a rate of one
// window per cycle, and captures the class index that the CNN returns.
// Optional feature macro: FEEDER_TERM_EN. When it is defined, the feeder
// adds a one-cycle end-of-sequence marker (X=OUT_DIM, Y=0, IMGIN=0) after the
// last window.
module cnn_window_feeder #(
    parameter int IMG_DIM = 28
) (
    input  logic                CLK,
    input  logic                nRST,
    cnn_window_feeder_if.slave  bus
);

    localparam int OUT_DIM = IMG_DIM - 4;
    localparam int NPIX    = IMG_DIM * IMG_DIM;
    localparam int IDX_W   = $clog2(NPIX);
    localparam logic [4:0] LAST_POS = 5'(OUT_DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_STREAM,
`ifdef FEEDER_TERM_EN
        S_TERM,
`endif
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic               pix_ready_q, pix_ready_d;
    logic               start_q, start_d;
    logic [4:0]         x_q, x_d;
    logic [4:0]         y_q, y_d;
    logic [199:0]       imgin_q, imgin_d;
    logic               win_valid_q, win_valid_d;
    logic [3:0]         result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               busy_q, busy_d;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_addr;
    logic [7:0]         pix_mem [NPIX];
    logic               accept;

    // Gathers the 5x5 neighbourhood whose top-left corner is (wx, wy).
    // Row k of the window occupies bytes k*5 .. k*5+4.
    function automatic logic [199:0] extract_window(input logic [4:0] wx, input logic [4:0] wy);
        logic [199:0]     w;
        logic [IDX_W-1:0] addr;
        w = '0;
        for (int k = 0; k < 5; k++) begin
            for (int l = 0; l < 5; l++) begin
                addr = IDX_W'((int'(wx) + k) * IMG_DIM + int'(wy) + l);
                w[(k*5+l)*8 +: 8] = pix_mem[addr];
            end
        end
        return w;
    endfunction

    assign accept = bus.PIX_VALID && pix_ready_q;

    // Next-state and next-output logic. Every output is computed one cycle
    // ahead so that it can leave the block straight from a flop.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        start_d        = 1'b0;
        win_valid_d    = 1'b0;
        x_d            = x_q;
        y_d            = y_q;
        imgin_d        = imgin_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = count_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mem_we   = 1'b1;
                    mem_addr = '0;
                    count_d  = IDX_W'(1);
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    mem_we = 1'b1;
                    if (count_q == IDX_W'(NPIX - 1)) begin
                        count_d = '0;
                        start_d = 1'b1;
                        state_d = S_KICK;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            S_KICK: begin
                win_valid_d = 1'b1;
                x_d         = '0;
                y_d         = '0;
                imgin_d     = extract_window(5'd0, 5'd0);
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                if (x_q == LAST_POS && y_q == LAST_POS) begin
`ifdef FEEDER_TERM_EN
                    x_d     = 5'(OUT_DIM);
                    y_d     = '0;
                    imgin_d = '0;
                    state_d = S_TERM;
`else
                    state_d = S_WAIT;
`endif
                end else begin
                    win_valid_d = 1'b1;
                    if (y_q == LAST_POS) begin
                        y_d = '0;
                        x_d = x_q + 5'd1;
                    end else begin
                        y_d = y_q + 5'd1;
                    end
                    imgin_d = extract_window(x_d, y_d);
                end
            end
`ifdef FEEDER_TERM_EN
            S_TERM: begin
                state_d = S_WAIT;
            end
`endif
            S_WAIT: begin
                if (bus.CNN_DONE) begin
                    result_d       = bus.CNN_OUT;
                    result_valid_d = 1'b1;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        pix_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    end

    // State and output registers, with a synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            pix_ready_q    <= 1'b1;
            start_q        <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            imgin_q        <= '0;
            win_valid_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            pix_ready_q    <= pix_ready_d;
            start_q        <= start_d;
            x_q            <= x_d;
            y_q            <= y_d;
            imgin_q        <= imgin_d;
            win_valid_q    <= win_valid_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    // Pixel buffer write port. Its contents are don't-care after reset,
    // because a new load always starts again at pixel 0.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            pix_mem[mem_addr] <= bus.PIX_IN;
        end
    end

    assign bus.PIX_READY    = pix_ready_q;
    assign bus.START        = start_q;
    assign bus.X            = x_q;
    assign bus.Y            = y_q;
    assign bus.IMGIN        = imgin_q;
    assign bus.WIN_VALID    = win_valid_q;
    assign bus.RESULT       = result_q;
    assign bus.RESULT_VALID = result_valid_q;
    assign bus.BUSY         = busy_q;

endmodule

// File: tb/tb_cnn_window_feeder.sv
// Testbench for cnn_window_feeder. It loads directed images, captures the
// window stream and compares it against a pixel model and a table of
// hand-computed vectors. It also covers the result handshake and resets
// applied in the middle of a stream.
module tb_cnn_window_feeder;

    localparam int IMG  = 28;
    localparam int OUTD = 24;
    localparam int NPIX = IMG * IMG;
    localparam int NWIN = OUTD * OUTD;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    cnn_window_feeder_if bus();

    cnn_window_feeder #(.IMG_DIM(IMG)) dut (
        .CLK  (clk),
        .nRST (n_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        int         byte_sel;
        logic [4:0] exp_x;
        logic [4:0] exp_y;
        logic [7:0] exp_byte;
    } win_vec_t;

    win_vec_t     vecs [10];
    int           tests_run    = 0;
    int           tests_failed = 0;
    logic [4:0]   cap_x   [NWIN];
    logic [4:0]   cap_y   [NWIN];
    logic [199:0] cap_img [NWIN];
    int           seen_24;
    int           stray;

    function automatic logic [7:0] img_pix(input int base, input int r, input int c);
        return 8'((r * IMG + c + base) & 255);
    endfunction

    function automatic logic [199:0] model_window(input int base, input int x, input int y);
        logic [199:0] w;
        w = '0;
        for (int k = 0; k < 5; k++)
            for (int l = 0; l < 5; l++)
                w[(k*5+l)*8 +: 8] = img_pix(base, x + k, y + l);
        return w;
    endfunction

    // Drives the master-side inputs of the interface.
    task automatic applyStimulus(input logic valid, input logic [7:0] pix,
                                 input logic done, input logic [3:0] cout);
        bus.PIX_VALID = valid;
        bus.PIX_IN    = pix;
        bus.CNN_DONE  = done;
        bus.CNN_OUT   = cout;
    endtask

    // Performs one counted comparison.
    task automatic checkOutput(input string name, input logic [199:0] actual,
                               input logic [199:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag, input logic [3:0] dummy);
        checkOutput({tag, "_pix_ready"},    200'(bus.PIX_READY),    200'(1));
        checkOutput({tag, "_start"},        200'(bus.START),        200'(0));
        checkOutput({tag, "_win_valid"},    200'(bus.WIN_VALID),    200'(0));
        checkOutput({tag, "_x"},            200'(bus.X),            200'(0));
        checkOutput({tag, "_y"},            200'(bus.Y),            200'(0));
        checkOutput({tag, "_imgin"},        bus.IMGIN,              200'(0));
        checkOutput({tag, "_result"},       200'(bus.RESULT),       200'(dummy));
        checkOutput({tag, "_result_valid"}, 200'(bus.RESULT_VALID), 200'(0));
        checkOutput({tag, "_busy"},         200'(bus.BUSY),         200'(0));
    endtask

    // The caller must be at a negedge. Each beat is driven at a negedge and
    // is accepted at the next posedge when ready is high. The task returns at
    // the negedge after the last accepted beat, and counts driven cycles and
    // RESULT_VALID observations.
    task automatic loadImage(input int base, input bit toggle, output int cycles, output int rv_cnt);
        int idx;
        bit phase;
        idx    = 0;
        phase  = 1'b1;
        cycles = 0;
        rv_cnt = 0;
        while (idx < NPIX && cycles < 4000) begin
            if (bus.RESULT_VALID) rv_cnt++;
            applyStimulus(toggle ? phase : 1'b1, img_pix(base, idx / IMG, idx % IMG), 1'b0, 4'd0);
            phase = !phase;
            if (bus.PIX_VALID && bus.PIX_READY) idx++;
            cycles++;
            @(negedge clk);
        end
        if (bus.RESULT_VALID) rv_cnt++;
        applyStimulus(1'b0, 8'h00, 1'b0, 4'd0);
    endtask

    // Starts at the KICK negedge and captures windows until WIN_VALID drops.
    // When stop_after > 0, the task returns at the negedge of that window.
    // A burst of CNN_DONE and PIX_VALID is injected mid-stream; both must be
    // ignored.
    task automatic captureStream(input logic [3:0] exp_result, input int stop_after, output int n);
        int guard;
        n       = 0;
        guard   = 0;
        seen_24 = 0;
        stray   = 0;
        @(negedge clk);
        while (bus.WIN_VALID && guard < 2 * NWIN) begin
            if (n < NWIN) begin
                cap_x[n]   = bus.X;
                cap_y[n]   = bus.Y;
                cap_img[n] = bus.IMGIN;
            end
            if (bus.X == 5'd24) seen_24++;
            if (bus.PIX_READY || bus.RESULT_VALID || bus.START || bus.RESULT != exp_result) stray++;
            n++;
            if (n == stop_after) return;
            if (n == 100) applyStimulus(1'b1, 8'hAA, 1'b1, 4'd9);
            if (n == 104) applyStimulus(1'b0, 8'h00, 1'b0, 4'd0);
            @(negedge clk);
            guard++;
        end
        if (bus.X == 5'd24) seen_24++;
    endtask

    task automatic verifyStream(input string tag, input int base, input int n);
        int seq_err;
        int data_err;
        seq_err  = 0;
        data_err = 0;
        checkOutput({tag, "_window_count"}, 200'(n), 200'(NWIN));
        for (int i = 0; i < NWIN; i++) begin
            if (cap_x[i] != 5'(i / OUTD) || cap_y[i] != 5'(i % OUTD)) seq_err++;
            if (cap_img[i] != model_window(base, i / OUTD, i % OUTD)) data_err++;
        end
        checkOutput({tag, "_xy_sequence"},   200'(seq_err),  200'(0));
        checkOutput({tag, "_window_data"},   200'(data_err), 200'(0));
        checkOutput({tag, "_stray_outputs"}, 200'(stray),    200'(0));
    endtask

    // Checks the KICK cycle and then the state after the stream ends.
    task automatic checkKick(input string tag);
        checkOutput({tag, "_kick_pix_ready"}, 200'(bus.PIX_READY), 200'(0));
        checkOutput({tag, "_kick_start"},     200'(bus.START),     200'(1));
        checkOutput({tag, "_kick_win_valid"}, 200'(bus.WIN_VALID), 200'(0));
    endtask

    task automatic checkStreamEnd(input string tag, input int base);
`ifdef FEEDER_TERM_EN
        checkOutput({tag, "_term_x"},     200'(bus.X), 200'(24));
        checkOutput({tag, "_term_y"},     200'(bus.Y), 200'(0));
        checkOutput({tag, "_term_imgin"}, bus.IMGIN,   200'(0));
`else
        checkOutput({tag, "_wait_x"},     200'(bus.X),   200'(23));
        checkOutput({tag, "_wait_y"},     200'(bus.Y),   200'(23));
        checkOutput({tag, "_wait_imgin"}, bus.IMGIN,     model_window(base, 23, 23));
        checkOutput({tag, "_no_x24"},     200'(seen_24), 200'(0));
`endif
        checkOutput({tag, "_end_win_valid"}, 200'(bus.WIN_VALID), 200'(0));
        checkOutput({tag, "_end_busy"},      200'(bus.BUSY),      200'(1));
    endtask

    // Completes the CNN handshake from WAIT. The caller must be at a negedge.
    task automatic finishCnn(input string tag, input logic [3:0] cls);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_wait_busy"}, 200'(bus.BUSY),      200'(1));
        checkOutput({tag, "_wait_rdy"},  200'(bus.PIX_READY), 200'(0));
        applyStimulus(1'b0, 8'h00, 1'b1, cls);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 1'b0, 4'd0);
        checkOutput({tag, "_result"},       200'(bus.RESULT),       200'(cls));
        checkOutput({tag, "_result_valid"}, 200'(bus.RESULT_VALID), 200'(1));
        checkOutput({tag, "_idle_busy"},    200'(bus.BUSY),         200'(0));
        checkOutput({tag, "_idle_ready"},   200'(bus.PIX_READY),    200'(1));
    endtask

    initial begin
        int cycles;
        int rv_cnt;
        int n;

        // Hand-computed windows for the image pixel(r,c) = (r*28+c) & 0xFF.
        vecs[0] = '{0,   0,  5'd0,  5'd0,  8'h00};
        vecs[1] = '{0,   24, 5'd0,  5'd0,  8'h74};
        vecs[2] = '{1,   0,  5'd0,  5'd1,  8'h01};
        vecs[3] = '{23,  4,  5'd0,  5'd23, 8'h1B};
        vecs[4] = '{24,  0,  5'd1,  5'd0,  8'h1C};
        vecs[5] = '{24,  12, 5'd1,  5'd0,  8'h56};
        vecs[6] = '{100, 20, 5'd4,  5'd4,  8'hE4};
        vecs[7] = '{245, 0,  5'd10, 5'd5,  8'h1D};
        vecs[8] = '{300, 7,  5'd12, 5'd12, 8'h7A};
        vecs[9] = '{575, 0,  5'd23, 5'd23, 8'h9B};

        applyStimulus(1'b0, 8'h00, 1'b0, 4'd0);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        checkResetState("reset", 4'd0);
        n_rst = 1'b1;

        // First image, with PIX_VALID held high continuously.
        loadImage(0, 1'b0, cycles, rv_cnt);
        checkOutput("load1_cycles", 200'(cycles), 200'(NPIX));
        checkKick("s1");
        captureStream(4'd0, 0, n);
        checkStreamEnd("s1", 0);
        verifyStream("s1", 0, n);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("vec%0d_x", i), 200'(cap_x[vecs[i].idx]), 200'(vecs[i].exp_x));
            checkOutput($sformatf("vec%0d_y", i), 200'(cap_y[vecs[i].idx]), 200'(vecs[i].exp_y));
            checkOutput($sformatf("vec%0d_byte", i),
                        200'(cap_img[vecs[i].idx][vecs[i].byte_sel*8 +: 8]), 200'(vecs[i].exp_byte));
        end
        finishCnn("cnn7", 4'd7);

        // The second load starts on the RESULT_VALID cycle, with PIX_VALID toggling.
        loadImage(0, 1'b1, cycles, rv_cnt);
        checkOutput("load2_cycles",      200'(cycles),     200'(2 * NPIX - 1));
        checkOutput("rv_single_pulse",   200'(rv_cnt),     200'(1));
        checkOutput("load2_result_kept", 200'(bus.RESULT), 200'(7));
        checkKick("s2");
        captureStream(4'd7, 0, n);
        checkStreamEnd("s2", 0);
        verifyStream("s2", 0, n);
        finishCnn("cnn5", 4'd5);

        // Reset during the stream, at window (10,5), then reload a new image.
        loadImage(0, 1'b0, cycles, rv_cnt);
        checkOutput("load3_cycles", 200'(cycles), 200'(NPIX));
        captureStream(4'd5, 246, n);
        checkOutput("mid_x", 200'(bus.X), 200'(10));
        checkOutput("mid_y", 200'(bus.Y), 200'(5));
        n_rst = 1'b0;
        @(negedge clk);
        checkResetState("midrst", 4'd0);
        n_rst = 1'b1;
        loadImage(64, 1'b0, cycles, rv_cnt);
        checkOutput("load4_cycles", 200'(cycles), 200'(NPIX));
        checkKick("s4");
        captureStream(4'd0, 0, n);
        checkStreamEnd("s4", 64);
        verifyStream("s4", 64, n);
        checkOutput("s4_first_byte", 200'(cap_img[0][7:0]), 200'(8'h40));
        finishCnn("cnn3", 4'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cnn_window_feeder.md
CNN_WINDOW_FEEDER -- requirements
Module: cnn_window_feeder

Interface
REQ-001 Parameter IMG_DIM, default 28, input image side in pixels; window side fixed at 5; OUT_DIM = IMG_DIM-4 (24 by default).
REQ-002 CLK  input  1  clock; all logic rising-edge.
REQ-003 nRST  input  1  reset, synchronous, active-low.
REQ-004 PIX_VALID  input  1  pixel stream valid.
REQ-005 PIX_IN  input  8  unsigned pixel, raster order, row 0 col 0 first, column fastest.
REQ-006 PIX_READY  output  1  feeder accepts PIX_IN this cycle.
REQ-007 START  output  1  one-cycle pulse announcing a window sequence to the CNN.
REQ-008 X  output  5  window top-left row index.
REQ-009 Y  output  5  window top-left column index.
REQ-010 IMGIN  output  200  5x5 window; byte (k*5+l) at bits [(k*5+l)*8 +: 8] = pixel(X+k, Y+l), k row, l column.
REQ-011 WIN_VALID  output  1  X/Y/IMGIN hold a real window this cycle.
REQ-012 CNN_DONE  input  1  CNN classification complete.
REQ-013 CNN_OUT  input  4  CNN class index, sampled when CNN_DONE=1.
REQ-014 RESULT  output  4  last captured class.
REQ-015 RESULT_VALID  output  1  one-cycle pulse when RESULT updates.
REQ-016 BUSY  output  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, LOAD, KICK, STREAM, TERM, WAIT; all outputs registered.
REQ-018 IDLE: PIX_READY=1; accepted beat (PIX_VALID&PIX_READY) writes pixel 0, count=1, goes to LOAD.
REQ-019 LOAD: PIX_READY=1; each accepted beat writes pixel[count], count+1; PIX_VALID=0 stalls without data loss; after pixel IMG_DIM*IMG_DIM-1 accepted -> KICK.
REQ-020 PIX_READY is 0 in KICK, STREAM, TERM, WAIT; PIX_VALID there is ignored.
REQ-021 KICK: START=1 for exactly one cycle, WIN_VALID=0 -> STREAM.
REQ-022 STREAM: one window per cycle, X,Y from (0,0) to (OUT_DIM-1,OUT_DIM-1), Y fastest; WIN_VALID=1; OUT_DIM*OUT_DIM consecutive cycles, no gaps.
REQ-023 First window appears the cycle after START; X/Y/IMGIN mutually consistent every WIN_VALID cycle.
REQ-024 After window (OUT_DIM-1,OUT_DIM-1): -> TERM if FEEDER_TERM_EN defined, else -> WAIT.
REQ-025 WAIT: WIN_VALID=0, X/Y/IMGIN hold last values; CNN_DONE=1 -> RESULT<=CNN_OUT, RESULT_VALID=1 next cycle, -> IDLE.
REQ-026 CNN_DONE outside WAIT is ignored; RESULT unchanged.
REQ-027 RESULT_VALID and an IDLE pixel accept may coincide; new load begins normally, RESULT retained.
REQ-028 Pixel buffer: IMG_DIM*IMG_DIM x 8 bits; window extraction reads only loaded pixels, no padding; counters never wrap past their limits.

Reset
REQ-029 nRST=0 at any clock edge, in any state: state=IDLE, count=0, START=0, WIN_VALID=0, X=0, Y=0, IMGIN=0, RESULT=0, RESULT_VALID=0, BUSY=0, PIX_READY=1 on the following cycle.
REQ-030 Reset mid-LOAD or mid-STREAM discards partial image; buffer contents don't-care; next load starts at pixel 0.

Configuration
REQ-031 Macro FEEDER_TERM_EN defined: TERM state drives one cycle X=OUT_DIM (24), Y=0, IMGIN=0, WIN_VALID=0 as end-of-sequence marker for the CNN, then -> WAIT.
REQ-032 FEEDER_TERM_EN undefined: no TERM state; STREAM -> WAIT directly, X/Y never exceed OUT_DIM-1.

Verification
REQ-033 Load pixel(r,c)=(r*28+c)&0xFF, PIX_VALID always 1 -> PIX_READY low after 784 beats, START pulse one cycle later, 576 windows; window (0,0) byte 0=0x00, byte 24=0x74; window (23,23) byte 0=0x9B (667&0xFF).
REQ-034 Same image, PIX_VALID toggling 1/0 -> identical window contents; LOAD lasts 1567 cycles.
REQ-035 FEEDER_TERM_EN defined -> cycle after window (23,23) shows X=24, Y=0, IMGIN=0; undefined -> no X=24 cycle ever.
REQ-036 In WAIT, CNN_DONE=1 with CNN_OUT=7 -> RESULT=7, RESULT_VALID single pulse, BUSY=0, PIX_READY=1; CNN_DONE during STREAM -> no RESULT change.
REQ-037 nRST=0 at window (10,5) -> all outputs at reset values next cycle; reload of a new image -> windows restart at (0,0) with new data.
